controle_id_rf: RTL and testbench
=================================

Name: controle_id_rf

Overview:
- Sequencer and arbiter for the ID/RF stage of the 16-bit datapath.
- Owns the single register-bank port set: shared write/read-A select BR_Sel_E_SA, BR_Sel_SB, BR_Hab_Escrita and the result-mux control.
- Arbitrates the register-bank write port between the ULA and MD writeback requesters.
- Tracks pending destination registers in an 8-entry scoreboard, stalls decode on RAW/WAW hazards, and issues instructions to EX with a valid/ready handshake.

Parameters:
- NUM_REGS, 8, number of architectural registers; select width is fixed at 3.
- SAT_MAX, 16'hFFFF, saturation value of the optional stall counters.

Ports:
- clock  in  1  rising-edge system clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decoded instruction present
- id_ready  out  1  instruction accepted this cycle
- id_rd  in  3  destination register, also source A (2-operand ISA)
- id_rt  in  3  source B register
- id_usa_rt  in  1  instruction reads id_rt
- id_escreve  in  1  instruction writes id_rd
- id_fonte  in  1  writeback source of instruction (0=ULA, 1=MD)
- ex_valid  out  1  issue register holds an instruction for EX
- ex_ready  in  1  EX accepts the issue register
- ex_rd  out  3  rd of issued instruction
- ex_fonte  out  1  fonte of issued instruction
- flush  in  1  discard issue register
- wb_ula_req  in  1  ULA writeback request
- wb_ula_rd  in  3  ULA writeback register
- wb_md_req  in  1  MD writeback request
- wb_md_rd  in  3  MD writeback register
- wb_ula_gnt  out  1  ULA write granted this cycle
- wb_md_gnt  out  1  MD write granted this cycle
- BR_Sel_E_SA  out  3  register-bank write/read-A select
- BR_Sel_SB  out  3  register-bank read-B select
- BR_Hab_Escrita  out  1  register-bank write enable
- controle  out  1  result mux select (0=entrada_ULA, 1=entrada_MD)
- pendentes  out  8  scoreboard bits
- erro_wb  out  1  sticky: writeback to a non-pending register

Behaviour:
- Reset: ex_valid=0, ex_rd=0, ex_fonte=0, pendentes=0, erro_wb=0, round-robin pointer=ULA, stats counters=0. Outputs are asynchronous-reset registers; combinational outputs follow.
- Cycle mode is combinational, in priority order: ESCRITA if any wb_*_req; else DECODE.
- ESCRITA mode:
  - One grant only. If a single request is present, grant it.
  - If both are present, round-robin: grant the side not granted last time; after reset ULA wins first.
  - Outputs: BR_Hab_Escrita=1, BR_Sel_E_SA=granted rd, controle=0 for ULA / 1 for MD, id_ready=0.
  - At the posedge, pendentes[granted rd] clears and the pointer updates.
  - The ungranted requester holds req and rd stable until granted.
- DECODE mode:
  - BR_Hab_Escrita=0, BR_Sel_E_SA=id_rd, BR_Sel_SB=id_rt. BR_Sel_SB is driven from id_rt in all modes.
  - Hazard = pendentes[id_rd] | (id_usa_rt & pendentes[id_rt]).
  - slot_livre = !ex_valid | ex_ready.
  - id_ready = id_valid & !hazard & slot_livre & !flush.
  - On accept at posedge: ex_valid=1, ex_rd=id_rd, ex_fonte=id_fonte; if id_escreve, pendentes[id_rd] sets.
  - Issue latency is 1 cycle: operands are selected in cycle N, ex_valid is seen in N+1.
- Issue register:
  - Holds while ex_valid & !ex_ready.
  - Clears on ex_ready when no new accept occurs.
  - Back-to-back accept and handoff is allowed in the same cycle.
- Set and clear of pendentes never occur in the same cycle, because writeback blocks decode.
- flush:
  - If the issue register holds an instruction not yet taken (ex_valid & !ex_ready) that set a pending bit, clear that bit and ex_valid.
  - If ex_ready=1 the same cycle, the handoff wins and flush has no effect on it.
  - Decode is blocked during flush.
- erro_wb sets when a granted rd is not pending; it clears only on reset.
- A reset mid-operation drops all pending bits and in-flight issue state immediately.

Optional Feature:
- Macro: CONTROLE_STATS_EN.
- When defined, adds outputs stall_hazard_cnt[15:0] and stall_wb_cnt[15:0]:
  - stall_hazard_cnt increments in cycles where id_valid & hazard & !flush in DECODE.
  - stall_wb_cnt increments in cycles where id_valid in ESCRITA mode.
  - Both saturate at SAT_MAX and reset to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Issue rd=3 escreve=1, ex_ready=1 -> id_ready=1, next cycle ex_valid=1, ex_rd=3, pendentes=8'h08.
- With pendentes=8'h08, present rd=5, rt=3, usa_rt=1 -> id_ready=0 until wb_ula_req rd=3 granted; then pendentes=0 and the instruction issues on the following cycle.
- wb_ula_req rd=1 and wb_md_req rd=2 in the same cycle after reset:
  - Cycle 1: ULA granted (BR_Sel_E_SA=1, controle=0).
  - Cycle 2: MD granted (BR_Sel_E_SA=2, controle=1).
  - The next simultaneous pair grants MD first.
- ex_ready=0 with ex_valid=1 and a new id_valid -> id_ready=0, ex_rd held; on ex_ready=1 the new instruction is accepted in the same cycle.
- Issue rd=6 escreve=1, ex_ready=0, then flush=1 -> ex_valid=0, pendentes[6]=0; wb_md_req rd=6 afterwards -> erro_wb=1.
- Assert reset mid-stall with pendentes=8'hFF -> pendentes=0, ex_valid=0 immediately; with CONTROLE_STATS_EN, both counters read 0.

Source files
------------

// File: rtl/controle_id_rf.sv
// ID/RF stage sequencer: register-bank port owner, writeback arbiter, pending-register scoreboard and EX issue register.
// Optional stall statistics (stall_hazard_cnt, stall_wb_cnt) are built when CONTROLE_STATS_EN is defined.
module controle_id_rf #(
    parameter int NUM_REGS = 8
`ifdef CONTROLE_STATS_EN
    , parameter logic [15:0] SAT_MAX = 16'hFFFF
`endif
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [2:0]          id_rd,
    input  logic [2:0]          id_rt,
    input  logic                id_usa_rt,
    input  logic                id_escreve,
    input  logic                id_fonte,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [2:0]          ex_rd,
    output logic                ex_fonte,
    input  logic                flush,
    input  logic                wb_ula_req,
    input  logic [2:0]          wb_ula_rd,
    input  logic                wb_md_req,
    input  logic [2:0]          wb_md_rd,
    output logic                wb_ula_gnt,
    output logic                wb_md_gnt,
    output logic [2:0]          BR_Sel_E_SA,
    output logic [2:0]          BR_Sel_SB,
    output logic                BR_Hab_Escrita,
    output logic                controle,
    output logic [NUM_REGS-1:0] pendentes,
    output logic                erro_wb
`ifdef CONTROLE_STATS_EN
    ,
    output logic [15:0]         stall_hazard_cnt,
    output logic [15:0]         stall_wb_cnt
`endif
);

    typedef enum logic {
        DECODE  = 1'b0,
        ESCRITA = 1'b1
    } modo_t;

    logic                r_ex_valid;
    logic [2:0]          r_ex_rd;
    logic                r_ex_fonte;
    logic                r_ex_escreve;
    logic [NUM_REGS-1:0] r_pendentes;
    logic                r_erro_wb;
    logic                r_prio_md;

    modo_t               w_modo;
    logic                w_gnt_ula;
    logic                w_gnt_md;
    logic [2:0]          w_wb_rd;
    logic                w_hazard;
    logic                w_slot_livre;
    logic                w_accept;
    logic                w_flush_hit;
    logic [NUM_REGS-1:0] w_pend_nxt;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_modo       = (wb_ula_req | wb_md_req) ? ESCRITA : DECODE;
        // r_prio_md only matters when both sides request at once.
        w_gnt_md     = wb_md_req & (!wb_ula_req | r_prio_md);
        w_gnt_ula    = wb_ula_req & (!wb_md_req | !r_prio_md);
        w_wb_rd      = w_gnt_md ? wb_md_rd : wb_ula_rd;
        w_hazard     = r_pendentes[id_rd] | (id_usa_rt & r_pendentes[id_rt]);
        w_slot_livre = !r_ex_valid | ex_ready;
        w_accept     = (w_modo == DECODE) & id_valid & !w_hazard & w_slot_livre & !flush;
        w_flush_hit  = flush & r_ex_valid & !ex_ready;

        w_pend_nxt = r_pendentes;
        if (w_modo == ESCRITA) begin
            w_pend_nxt[w_wb_rd] = 1'b0;
        end
        if (w_flush_hit && r_ex_escreve) begin
            w_pend_nxt[r_ex_rd] = 1'b0;
        end
        if (w_accept && id_escreve) begin
            w_pend_nxt[id_rd] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_rd      <= 3'd0;
            r_ex_fonte   <= 1'b0;
            r_ex_escreve <= 1'b0;
            r_pendentes  <= '0;
            r_erro_wb    <= 1'b0;
            r_prio_md    <= 1'b0;
        end else begin
            r_pendentes <= w_pend_nxt;
            if (w_accept) begin
                r_ex_valid   <= 1'b1;
                r_ex_rd      <= id_rd;
                r_ex_fonte   <= id_fonte;
                r_ex_escreve <= id_escreve;
            end else if (ex_ready || w_flush_hit) begin
                r_ex_valid <= 1'b0;
            end
            if (w_modo == ESCRITA && !r_pendentes[w_wb_rd]) begin
                r_erro_wb <= 1'b1;
            end
            // The pointer moves only on contested cycles; a lone request does not consume a turn.
            if (wb_ula_req && wb_md_req) begin
                r_prio_md <= w_gnt_ula;
            end
        end
    end

`ifdef CONTROLE_STATS_EN
    logic [15:0] r_stall_hazard_cnt;
    logic [15:0] r_stall_wb_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_hazard_cnt <= 16'd0;
            r_stall_wb_cnt     <= 16'd0;
        end else begin
            if (w_modo == DECODE && id_valid && w_hazard && !flush && r_stall_hazard_cnt != SAT_MAX) begin
                r_stall_hazard_cnt <= r_stall_hazard_cnt + 16'd1;
            end
            if (w_modo == ESCRITA && id_valid && r_stall_wb_cnt != SAT_MAX) begin
                r_stall_wb_cnt <= r_stall_wb_cnt + 16'd1;
            end
        end
    end

    assign stall_hazard_cnt = r_stall_hazard_cnt;
    assign stall_wb_cnt     = r_stall_wb_cnt;
`endif

    assign id_ready       = w_accept;
    assign ex_valid       = r_ex_valid;
    assign ex_rd          = r_ex_rd;
    assign ex_fonte       = r_ex_fonte;
    assign wb_ula_gnt     = w_gnt_ula;
    assign wb_md_gnt      = w_gnt_md;
    assign BR_Hab_Escrita = (w_modo == ESCRITA);
    assign BR_Sel_E_SA    = (w_modo == ESCRITA) ? w_wb_rd : id_rd;
    assign BR_Sel_SB      = id_rt;
    assign controle       = w_gnt_md;
    assign pendentes      = r_pendentes;
    assign erro_wb        = r_erro_wb;

endmodule

// File: tb/tb_controle_id_rf.sv
// Directed bench for controle_id_rf: a cycle-by-cycle vector table plus hand sequences for arbitration order and mid-stall reset.
module tb_controle_id_rf;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid, id_ready;
    logic [2:0] id_rd, id_rt;
    logic       id_usa_rt, id_escreve, id_fonte;
    logic       ex_valid, ex_ready;
    logic [2:0] ex_rd;
    logic       ex_fonte, flush;
    logic       wb_ula_req, wb_md_req;
    logic [2:0] wb_ula_rd, wb_md_rd;
    logic       wb_ula_gnt, wb_md_gnt;
    logic [2:0] BR_Sel_E_SA, BR_Sel_SB;
    logic       BR_Hab_Escrita, controle;
    logic [7:0] pendentes;
    logic       erro_wb;
`ifdef CONTROLE_STATS_EN
    logic [15:0] stall_hazard_cnt, stall_wb_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    controle_id_rf dut (
        .clock(clock), .reset(reset),
        .id_valid(id_valid), .id_ready(id_ready), .id_rd(id_rd), .id_rt(id_rt),
        .id_usa_rt(id_usa_rt), .id_escreve(id_escreve), .id_fonte(id_fonte),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_fonte(ex_fonte),
        .flush(flush),
        .wb_ula_req(wb_ula_req), .wb_ula_rd(wb_ula_rd), .wb_md_req(wb_md_req), .wb_md_rd(wb_md_rd),
        .wb_ula_gnt(wb_ula_gnt), .wb_md_gnt(wb_md_gnt),
        .BR_Sel_E_SA(BR_Sel_E_SA), .BR_Sel_SB(BR_Sel_SB), .BR_Hab_Escrita(BR_Hab_Escrita),
        .controle(controle), .pendentes(pendentes), .erro_wb(erro_wb)
`ifdef CONTROLE_STATS_EN
        , .stall_hazard_cnt(stall_hazard_cnt), .stall_wb_cnt(stall_wb_cnt)
`endif
    );

    // One cycle: inputs, then outputs expected just before the next rising edge.
    typedef struct {
        int vld, rd, rt, usa, esc, fon, exr, fl, uq, urd, mq, mrd;
        int rdy, exv, exrd, exf, pend, hab, sa, sb, ctl, ug, mg, err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rd = 0; id_rt = 0; id_usa_rt = 0; id_escreve = 0; id_fonte = 0;
        ex_ready = 0; flush = 0; wb_ula_req = 0; wb_ula_rd = 0; wb_md_req = 0; wb_md_rd = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    vec_t tv [19];
    logic [31:0] got_v, want_v;

    initial begin
        tv = '{
            // vld rd rt usa esc fon exr fl uq urd mq mrd | rdy exv exrd exf pend hab sa sb ctl ug mg err
            '{0,0,0,0,0,0,0,0,0,0,0,0,  0,0,0,0,'h00,0,0,0,0,0,0,0}, // idle after reset
            '{1,3,0,0,1,0,1,0,0,0,0,0,  1,0,0,0,'h00,0,3,0,0,0,0,0}, // issue rd=3
            '{1,5,3,1,1,0,1,0,0,0,0,0,  0,1,3,0,'h08,0,5,3,0,0,0,0}, // RAW on rt=3
            '{1,5,3,1,1,0,1,0,1,3,0,0,  0,0,3,0,'h08,1,3,3,0,1,0,0}, // ULA wb rd=3 blocks decode
            '{1,5,3,1,1,0,1,0,0,0,0,0,  1,0,3,0,'h00,0,5,3,0,0,0,0}, // hazard gone, issue rd=5
            '{1,1,0,0,1,1,0,0,0,0,0,0,  0,1,5,0,'h20,0,1,0,0,0,0,0}, // EX backpressure
            '{1,1,0,0,1,1,1,0,0,0,0,0,  1,1,5,0,'h20,0,1,0,0,0,0,0}, // handoff + accept
            '{1,6,5,0,1,0,1,0,0,0,0,0,  1,1,1,1,'h22,0,6,5,0,0,0,0}, // rt pending but unused
            '{0,0,0,0,0,0,0,1,0,0,0,0,  0,1,6,0,'h62,0,0,0,0,0,0,0}, // flush held rd=6
            '{0,0,0,0,0,0,0,0,0,0,1,6,  0,0,6,0,'h22,1,6,0,1,0,1,0}, // MD wb to non-pending rd=6
            '{1,1,0,0,1,0,1,0,0,0,0,0,  0,0,6,0,'h22,0,1,0,0,0,0,1}, // WAW on rd=1, erro set
            '{0,0,0,0,0,0,0,0,1,5,1,1,  0,0,6,0,'h22,1,5,0,0,1,0,1}, // contest: ULA first
            '{0,0,0,0,0,0,0,0,0,0,1,1,  0,0,6,0,'h02,1,1,0,1,0,1,1}, // MD held, now granted
            '{0,0,0,0,0,0,0,0,1,2,1,3,  0,0,6,0,'h00,1,3,0,1,0,1,1}, // next contest: MD first
            '{1,0,0,0,0,0,1,0,1,2,0,0,  0,0,6,0,'h00,1,2,0,0,1,0,1}, // ULA held, decode blocked
            '{1,0,0,0,0,0,1,1,0,0,0,0,  0,0,6,0,'h00,0,0,0,0,0,0,1}, // flush blocks decode
            '{1,4,0,0,1,0,1,0,0,0,0,0,  1,0,6,0,'h00,0,4,0,0,0,0,1}, // issue rd=4
            '{0,0,0,0,0,0,1,1,0,0,0,0,  0,1,4,0,'h10,0,0,0,0,0,0,1}, // flush with ex_ready: handoff wins
            '{0,0,0,0,0,0,0,0,0,0,0,0,  0,0,4,0,'h10,0,0,0,0,0,0,1}  // rd=4 still pending
        };

        do_reset();
        @(negedge clock);
        check("reset_state", {24'd0, ex_valid, ex_rd, ex_fonte, erro_wb, pendentes == 8'h00},
              {24'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1});
        @(posedge clock);
        #1;

        for (int i = 0; i < 19; i++) begin
            id_valid = 1'(tv[i].vld); id_rd = 3'(tv[i].rd); id_rt = 3'(tv[i].rt);
            id_usa_rt = 1'(tv[i].usa); id_escreve = 1'(tv[i].esc); id_fonte = 1'(tv[i].fon);
            ex_ready = 1'(tv[i].exr); flush = 1'(tv[i].fl);
            wb_ula_req = 1'(tv[i].uq); wb_ula_rd = 3'(tv[i].urd);
            wb_md_req = 1'(tv[i].mq); wb_md_rd = 3'(tv[i].mrd);
            @(negedge clock);
            got_v = {7'd0, id_ready, ex_valid, ex_rd, ex_fonte, pendentes, BR_Hab_Escrita,
                     BR_Sel_E_SA, BR_Sel_SB, controle, wb_ula_gnt, wb_md_gnt, erro_wb};
            want_v = {7'd0, 1'(tv[i].rdy), 1'(tv[i].exv), 3'(tv[i].exrd), 1'(tv[i].exf),
                      8'(tv[i].pend), 1'(tv[i].hab), 3'(tv[i].sa), 3'(tv[i].sb),
                      1'(tv[i].ctl), 1'(tv[i].ug), 1'(tv[i].mg), 1'(tv[i].err)};
            check($sformatf("vec%0d", i), got_v, want_v);
            @(posedge clock);
            #1;
        end

        // Arbitration order straight out of reset: ULA, then held MD, then MD wins the next contest.
        do_reset();
        wb_ula_req = 1; wb_ula_rd = 1; wb_md_req = 1; wb_md_rd = 2;
        @(negedge clock);
        check("arb_first", {27'd0, BR_Hab_Escrita, BR_Sel_E_SA, controle},
              {27'd0, 1'b1, 3'd1, 1'b0});
        @(posedge clock);
        #1 wb_ula_req = 0;
        @(negedge clock);
        check("arb_second", {27'd0, BR_Hab_Escrita, BR_Sel_E_SA, controle},
              {27'd0, 1'b1, 3'd2, 1'b1});
        @(posedge clock);
        #1 wb_ula_req = 1; wb_ula_rd = 3; wb_md_req = 1; wb_md_rd = 4;
        @(negedge clock);
        check("arb_third", {26'd0, BR_Sel_E_SA, controle, wb_md_gnt, erro_wb},
              {26'd0, 3'd4, 1'b1, 1'b1, 1'b1});

        // Fill the scoreboard, stall on a hazard with EX blocked, then reset asynchronously mid-cycle.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            id_valid = 1; id_rd = 3'(r); id_escreve = 1; ex_ready = 1;
            @(posedge clock);
            #1;
        end
        id_valid = 1; id_rd = 3'd0; ex_ready = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("stall_full", {22'd0, pendentes, id_ready, ex_valid},
              {22'd0, 8'hFF, 1'b0, 1'b1});
`ifdef CONTROLE_STATS_EN
        check("stall_hazard_cnt", {16'd0, stall_hazard_cnt}, 32'd3);
`endif
        #1 reset = 1'b1;
        #1;
        check("reset_mid", {22'd0, pendentes, ex_valid, erro_wb}, 32'd0);
`ifdef CONTROLE_STATS_EN
        check("reset_cnts", {stall_hazard_cnt, stall_wb_cnt}, 32'd0);
`endif
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
